// File: rtl/des_core_iter.sv
// rtl/des_core_iter.sv - iterative DES round engine with valid/ready handshakes
// Optional decrypt path enabled by defining DES_CORE_DECRYPT_EN.
module des_core_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in,
    input  logic [55:0] key,
    input  logic        decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    // Bit i set: round i rotates by one, otherwise by two.
    localparam logic [15:0] SHIFT1   = 16'b1000000100000011;
    localparam logic [3:0]  RND_STEP = 4'(ROUNDS_PER_CYCLE);
    localparam logic [3:0]  RND_LAST = 4'(ROUNDS_PER_CYCLE - 1);

    localparam int E_TAB [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9,10,11,12,13,12,13,14,15,16,17,
        16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32, 1};
    localparam int P_TAB [32] = '{
        16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
         2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
    localparam int PC2_TAB [48] = '{
        14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
        41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int FP_TAB [64] = '{
        40, 8,48,16,56,24,64,32,39, 7,47,15,55,23,63,31,
        38, 6,46,14,54,22,62,30,37, 5,45,13,53,21,61,29,
        36, 4,44,12,52,20,60,28,35, 3,43,11,51,19,59,27,
        34, 2,42,10,50,18,58,26,33, 1,41, 9,49,17,57,25};
    localparam int SBOX [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    function automatic logic [47:0] expansion(input logic [31:0] r);
        logic [47:0] o;
        for (int j = 0; j < 48; j++) o[47-j] = r[32-E_TAB[j]];
        return o;
    endfunction

    function automatic logic [47:0] key_mixer(input logic [47:0] e, input logic [47:0] k);
        return e ^ k;
    endfunction

    function automatic logic [31:0] s_function(input logic [47:0] x);
        logic [31:0] o;
        logic [5:0]  six;
        int          v;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            v   = SBOX[b*64 + 32*int'(six[5]) + 16*int'(six[0]) + int'(six[4:1])];
            o[31-4*b -: 4] = v[3:0];
        end
        return o;
    endfunction

    function automatic logic [31:0] p_post_sf(input logic [31:0] s);
        logic [31:0] o;
        for (int j = 0; j < 32; j++) o[31-j] = s[32-P_TAB[j]];
        return o;
    endfunction

    function automatic logic [47:0] p_key2(input logic [55:0] cd);
        logic [47:0] o;
        for (int j = 0; j < 48; j++) o[47-j] = cd[56-PC2_TAB[j]];
        return o;
    endfunction

    function automatic logic [63:0] p_inverse(input logic [63:0] x);
        logic [63:0] o;
        for (int j = 0; j < 64; j++) o[63-j] = x[64-FP_TAB[j]];
        return o;
    endfunction

    // Per-round key-half rotation; decrypt walks the schedule backwards.
    function automatic logic [27:0] rot_step(input logic [27:0] v, input logic [3:0] i,
                                             input logic dec);
        logic [27:0] o;
        o = v;
        if (!dec) begin
            o = SHIFT1[i] ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
        end
`ifdef DES_CORE_DECRYPT_EN
        else if (i != 4'd0) begin
            o = SHIFT1[4'd0 - i] ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
        end
`endif
        return o;
    endfunction

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] l_q, r_q, l_n, r_n;
    logic [27:0] c_q, d_q, c_n, d_n;
    logic [3:0]  rnd_q;
    logic        mode_q;
    logic        last_step;

`ifndef DES_CORE_DECRYPT_EN
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
`endif

    assign last_step = (rnd_q + RND_LAST) == 4'd15;
    assign out       = p_inverse({r_q, l_q});

    always_comb begin
        l_n = l_q;
        r_n = r_q;
        c_n = c_q;
        d_n = d_q;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            c_n = rot_step(c_n, rnd_q + 4'(k), mode_q);
            d_n = rot_step(d_n, rnd_q + 4'(k), mode_q);
            {l_n, r_n} = {r_n, l_n ^ p_post_sf(s_function(key_mixer(expansion(r_n),
                                                                      p_key2({c_n, d_n}))))};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: if (last_step) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_q    <= '0;
            r_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
            rnd_q  <= '0;
            mode_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            l_q    <= in[63:32];
            r_q    <= in[31:0];
            c_q    <= key[27:0];
            d_q    <= key[55:28];
            rnd_q  <= '0;
`ifdef DES_CORE_DECRYPT_EN
            mode_q <= decrypt;
`else
            mode_q <= 1'b0;
`endif
        end else if (state_q == BUSY) begin
            l_q   <= l_n;
            r_q   <= r_n;
            c_q   <= c_n;
            d_q   <= d_n;
            rnd_q <= rnd_q + RND_STEP;
        end
    end

endmodule

// File: tb/tb_des_core_iter.sv
// tb/tb_des_core_iter.sv - table-driven bench for des_core_iter at 1/2/4/8/16 rounds per cycle
module tb_des_core_iter;

    localparam int NDUT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] blk_in = '0;
    logic [55:0] key_in = '0;
    logic        dec_in = 1'b0;
    logic        out_ready = 1'b0;
    logic [NDUT-1:0] in_ready_v;
    logic [NDUT-1:0] out_valid_v;
    logic [63:0]     out_v [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        des_core_iter #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .in        (blk_in),
            .key       (key_in),
            .decrypt   (dec_in),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .out       (out_v[g])
        );
    end

    // Reference DES tables, 1-based bit positions counted from the MSB.
    localparam int T_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int T_E [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9,10,11,12,13,12,13,14,15,16,17,
        16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32, 1};
    localparam int T_P [32] = '{
        16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
         2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
    localparam int T_PC2 [48] = '{
        14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
        41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int T_FP [64] = '{
        40, 8,48,16,56,24,64,32,39, 7,47,15,55,23,63,31,
        38, 6,46,14,54,22,62,30,37, 5,45,13,53,21,61,29,
        36, 4,44,12,52,20,60,28,35, 3,43,11,51,19,59,27,
        34, 2,42,10,50,18,58,26,33, 1,41, 9,49,17,57,25};
    localparam int T_S [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, p;
        int six, row, col;
        for (int j = 1; j <= 48; j++) x[48-j] = r[32-T_E[j-1]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = int'(x[47-6*b -: 6]);
            row = ((six >> 4) & 2) | (six & 1);
            col = (six >> 1) & 15;
            s[31-4*b -: 4] = 4'(T_S[b*64 + row*16 + col]);
        end
        for (int j = 1; j <= 32; j++) p[32-j] = s[32-T_P[j-1]];
        return p;
    endfunction

    // Subkeys are precomputed and simply used in reverse order for decrypt.
    function automatic logic [63:0] des_model(input logic [63:0] b, input logic [55:0] kin,
                                              input logic dec);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] sk [16];
        logic [31:0] l, r, t;
        logic [63:0] x, o;
        c = kin[27:0];
        d = kin[55:28];
        for (int i = 0; i < 16; i++) begin
            for (int n = 0; n < T_SH[i]; n++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 1; j <= 48; j++) sk[i][48-j] = cd[56-T_PC2[j-1]];
        end
        l = b[63:32];
        r = b[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ m_f(r, dec ? sk[15-i] : sk[i]);
            l = t;
        end
        x = {r, l};
        for (int j = 1; j <= 64; j++) o[64-j] = x[64-T_FP[j-1]];
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] b, input logic [55:0] kin, input logic dec);
        @(negedge clk);
        in_valid = 1'b1;
        blk_in   = b;
        key_in   = kin;
        dec_in   = dec;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Accept, measure latency on every instance, compare data, then drain.
    task automatic run_vec(input string name, input logic [63:0] b, input logic [55:0] kin,
                           input logic dec, input logic [63:0] exp);
        int lat [NDUT];
        for (int g = 0; g < NDUT; g++) lat[g] = 99;
        send(b, kin, dec);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++)
                if (lat[g] == 99 && out_valid_v[g]) lat[g] = cyc;
        end
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s latency rpc=%0d", name, 1 << g), 64'(lat[g]), 64'(16 >> g));
            check($sformatf("%s data rpc=%0d", name, 1 << g), out_v[g], exp);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("%s back to idle", name), {54'd0, in_ready_v, out_valid_v},
              {54'd0, 5'h1f, 5'h00});
    endtask

    typedef struct {
        string       name;
        logic [63:0] blk;
        logic [55:0] key;
        logic        dec;
        logic [63:0] exp;
    } vec_t;

    localparam logic [55:0] K_PLAN = 56'h00FEDCBA987654;
    localparam logic [55:0] K_RT   = 56'h0F1E2D3C4B5A69;
    localparam logic [63:0] B_PLAN = 64'h0123456789ABCDEF;

    initial begin
        vec_t vecs [6];
        logic [63:0] enc0, enc1, plan_exp;
        logic        ok_flag;

        enc0     = des_model(64'h0, K_RT, 1'b0);
        enc1     = des_model(64'hFFFFFFFFFFFFFFFF, K_RT, 1'b0);
        plan_exp = des_model(B_PLAN, K_PLAN, 1'b0);

        // Textbook vector (IP already applied to the block, PC1 to the key).
        vecs[0] = '{"kat",   64'hCC00CCFFF0AAF0AA, 56'h556678FF0CCAAF, 1'b0, 64'h85E813540F0AB405};
        vecs[1] = '{"plan",  B_PLAN, K_PLAN, 1'b0, plan_exp};
        vecs[2] = '{"zeros", 64'h0, K_RT, 1'b0, enc0};
        vecs[3] = '{"ones",  64'hFFFFFFFFFFFFFFFF, K_RT, 1'b0, enc1};
`ifdef DES_CORE_DECRYPT_EN
        vecs[4] = '{"rt_zeros", enc0, K_RT, 1'b1, 64'h0};
        vecs[5] = '{"rt_ones",  enc1, K_RT, 1'b1, 64'hFFFFFFFFFFFFFFFF};
`else
        vecs[4] = '{"dec_ignored", B_PLAN, K_PLAN, 1'b1, plan_exp};
        vecs[5] = '{"dec_ignored2", enc0, K_RT, 1'b1, des_model(enc0, K_RT, 1'b0)};
`endif

        #2;
        check("reset flags", {54'd0, in_ready_v, out_valid_v}, {54'd0, 5'h1f, 5'h00});
        check("reset out", out_v[0], 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i].name, vecs[i].blk, vecs[i].key, vecs[i].dec, vecs[i].exp);

        // Backpressure: hold DONE for 10 cycles while junk pulses arrive.
        send(B_PLAN, K_PLAN, 1'b0);
        for (int cyc = 1; cyc <= 20 && !out_valid_v[0]; cyc++) @(negedge clk);
        for (int cyc = 0; cyc < 10; cyc++) begin
            check($sformatf("hold flags %0d", cyc), {54'd0, in_ready_v, out_valid_v},
                  {54'd0, 5'h00, 5'h1f});
            check($sformatf("hold data %0d", cyc), out_v[0], plan_exp);
            in_valid = ~in_valid;
            blk_in   = ~plan_exp;
            key_in   = K_RT;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold release idle", {54'd0, in_ready_v, out_valid_v}, {54'd0, 5'h1f, 5'h00});

        // Asynchronous reset five cycles into BUSY.
        send(B_PLAN, K_PLAN, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst flags", {54'd0, in_ready_v, out_valid_v}, {54'd0, 5'h1f, 5'h00});
        check("async rst out", out_v[0], 64'h0);
        @(negedge clk);
        rst = 1'b0;
        ok_flag = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (out_valid_v != '0) ok_flag = 1'b0;
        end
        check("no valid after rst", {63'd0, ok_flag}, 64'd1);
        run_vec("after_rst", B_PLAN, K_PLAN, 1'b0, plan_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
